// File: rtl/aes_word_loader_if.sv
// Word-stream bundle for aes_word_loader: 32-bit input words in, 32-bit ciphertext words out.
interface aes_word_loader_if;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        in_keep_key;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output in_data, in_valid, in_keep_key, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, in_keep_key, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/aes_word_loader.sv
// Loads key + plaintext words, pulses the AES core, drains ciphertext words; watchdog aborts a hung core.
// Skipping the key load on in_keep_key is built only with AES_KEY_REUSE_EN defined.
module aes_word_loader #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rstn,
   aes_word_loader_if.slave  words,
   output logic              aes_start,
   output logic [127:0]      aes_plain_text,
   output logic [127:0]      aes_cipher_key,
   input  logic              aes_done,
   input  logic [127:0]      aes_cipher_text,
   output logic              busy,
   output logic              err_timeout
);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {LOAD_KEY, LOAD_PT, START, WAIT, DRAIN} state_t;

   state_t          state, state_nxt;
   logic [1:0]      cnt, cnt_nxt;
   logic [WD_W-1:0] wd_cnt;
   logic [127:0]    ct_sr;
   logic            key_valid;
   logic            in_ready_q, out_valid_q;
   logic            in_xfer, reuse_hit;
   logic            key_shift, pt_shift, key_done, timeout_hit;

   assign in_xfer = words.in_valid && in_ready_q;

`ifdef AES_KEY_REUSE_EN
   assign reuse_hit = in_xfer && (state == LOAD_KEY) && (cnt == 2'd0) && words.in_keep_key && key_valid;
`else
   assign reuse_hit = 1'b0;
   logic unused_keep;
   assign unused_keep = words.in_keep_key;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= LOAD_KEY;
         cnt   <= 2'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // The 2-bit counter wraps to 0 on the 4th word, which doubles as the clear on state change.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      key_shift   = 1'b0;
      pt_shift    = 1'b0;
      key_done    = 1'b0;
      timeout_hit = 1'b0;
      unique case (state)
         LOAD_KEY: begin
            if (reuse_hit) begin
               pt_shift  = 1'b1;
               cnt_nxt   = 2'd1;
               state_nxt = LOAD_PT;
            end else if (in_xfer) begin
               key_shift = 1'b1;
               cnt_nxt   = cnt + 2'd1;
               if (cnt == 2'd3) begin
                  key_done  = 1'b1;
                  state_nxt = LOAD_PT;
               end
            end
         end
         LOAD_PT: begin
            if (in_xfer) begin
               pt_shift = 1'b1;
               cnt_nxt  = cnt + 2'd1;
               if (cnt == 2'd3) state_nxt = START;
            end
         end
         START: state_nxt = WAIT;
         WAIT: begin
            if (aes_done) begin
               state_nxt = DRAIN;
            end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
               timeout_hit = 1'b1;
               state_nxt   = LOAD_KEY;
            end
         end
         DRAIN: begin
            if (words.out_ready) begin
               cnt_nxt = cnt + 2'd1;
               if (cnt == 2'd3) state_nxt = LOAD_KEY;
            end
         end
         default: state_nxt = LOAD_KEY;
      endcase
   end

   // Handshake and status outputs are registered decodes of the next state so they read 0 in reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         aes_cipher_key <= '0;
         aes_plain_text <= '0;
         ct_sr          <= '0;
         wd_cnt         <= '0;
         key_valid      <= 1'b0;
         in_ready_q     <= 1'b0;
         out_valid_q    <= 1'b0;
         aes_start      <= 1'b0;
         busy           <= 1'b0;
         err_timeout    <= 1'b0;
      end else begin
         if (key_shift) aes_cipher_key <= {aes_cipher_key[95:0], words.in_data};
         if (pt_shift)  aes_plain_text <= {aes_plain_text[95:0], words.in_data};

         if (state == START)     wd_cnt <= '0;
         else if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;

         if (state == WAIT && aes_done)               ct_sr <= aes_cipher_text;
         else if (state == DRAIN && words.out_ready)  ct_sr <= {ct_sr[95:0], 32'h0};

         if (timeout_hit)   key_valid <= 1'b0;
         else if (key_done) key_valid <= 1'b1;

         in_ready_q  <= (state_nxt == LOAD_KEY) || (state_nxt == LOAD_PT);
         out_valid_q <= (state_nxt == DRAIN);
         aes_start   <= (state_nxt == START);
         busy        <= (state_nxt == START) || (state_nxt == WAIT);
         err_timeout <= timeout_hit;
      end
   end

   assign words.in_ready  = in_ready_q;
   assign words.out_valid = out_valid_q;
   assign words.out_data  = ct_sr[127:96];
endmodule

// File: doc/aes_word_loader.md
# aes_word_loader

Host-side adapter that sits directly upstream and downstream of the AES encryption top. It collects a 128-bit cipher key and a 128-bit plaintext from a 32-bit valid/ready word stream. It then pulses the encryptor's start, waits for its done, and streams the 128-bit ciphertext back out as four 32-bit words. A watchdog aborts the block if done never arrives.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum cycles spent in WAIT before abort (≥ 16).
- `clk`, in, 1: single clock, rising edge.
- `rstn`, in, 1: synchronous, active-low reset.
- `in_data`, in, 32: input word, most-significant word first.
- `in_valid`, in, 1: input word valid.
- `in_ready`, out, 1: block accepts a word this cycle.
- `in_keep_key`, in, 1: sampled with the first word of a block; only used under `AES_KEY_REUSE_EN`.
- `aes_start`, out, 1: one-cycle start pulse to the encryptor.
- `aes_plain_text`, out, 128: plaintext register.
- `aes_cipher_key`, out, 128: key register.
- `aes_done`, in, 1: encryptor done (level or pulse).
- `aes_cipher_text`, in, 128: encryptor result.
- `out_data`, out, 32: ciphertext word, most-significant first.
- `out_valid`, out, 1: output word valid.
- `out_ready`, in, 1: sink accepts the word.
- `busy`, out, 1: high in START and WAIT.
- `err_timeout`, out, 1: one-cycle pulse on watchdog abort.

## Operation
- States: LOAD_KEY (reset state), LOAD_PT, START, WAIT, DRAIN.
- A word transfers when `in_valid && in_ready`. `in_ready` = 1 only in LOAD_KEY and LOAD_PT.
- A 2-bit word counter counts transfers in the load states and DRAIN, and clears on every state change.
- LOAD_KEY: each transfer shifts `aes_cipher_key <= {aes_cipher_key[95:0], in_data}`. After the 4th transfer, set `key_valid` and go to LOAD_PT.
- LOAD_PT: same shift into `aes_plain_text`. After the 4th transfer, go to START.
- START: `aes_start` = 1 for exactly one cycle. Clear the watchdog counter. Go to WAIT. `aes_done` is ignored in this cycle.
- WAIT: the watchdog counts cycles.
  - First cycle with `aes_done` = 1: capture `aes_cipher_text` into a 128-bit output shift register and go to DRAIN.
  - If the counter reaches `TIMEOUT_CYCLES - 1` without done: pulse `err_timeout`, go to LOAD_KEY, and clear `key_valid`.
  - If done and timeout fall on the same cycle, done wins.
- DRAIN: `out_valid` = 1 and `out_data` = shift register [127:96]. On `out_ready`, shift left by 32. After the 4th accepted word, drop `out_valid` and go to LOAD_KEY.
- DRAIN and the load states never overlap: no input is accepted while ciphertext is pending.
- `aes_plain_text` and `aes_cipher_key` change only on accepted words, so they are stable from START through DRAIN.
- Reset value of every output is 0. The key, plaintext and output shift registers, counters and `key_valid` are all 0 after reset.
- `rstn` low in any state, including mid-load, WAIT or DRAIN: the block returns to LOAD_KEY on the next edge, and partial words are discarded.

## Timing
- Last plaintext word accepted in cycle t → `aes_start` high in t+1 → WAIT from t+2.
- `aes_done` first seen in cycle d → `out_valid` high from d+1.
- With `out_ready` held at 1, the four output words occupy d+1..d+4, and `in_ready` rises at d+5.
- `in_ready` and `out_valid` are pure state decodes, never combinational from `in_valid` or `out_ready`.
- Minimum input load: 8 cycles, or 4 under key reuse.

## Configuration
- `AES_KEY_REUSE_EN` defined:
  - In LOAD_KEY, if the first word arrives with `in_keep_key` = 1 and `key_valid` = 1, that word is the first plaintext word. It shifts into `aes_plain_text`, the counter becomes 1 and the state moves to LOAD_PT.
  - If `key_valid` = 0, `in_keep_key` is ignored.
- Undefined: `in_keep_key` is ignored, and every block loads 4 key words followed by 4 plaintext words.

## Test plan
- FIPS-197 vector, no stalls, real encryptor attached:
  - Key words 00010203, 04050607, 08090a0b, 0c0d0e0f.
  - Plaintext words 00112233, 44556677, 8899aabb, ccddeeff.
  - Required: one `aes_start` pulse, then `out_data` 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
- Backpressure: random `in_valid` and `out_ready` gaps (≥ 3-cycle stalls). Required: same ciphertext, no dropped or duplicated words, `out_data` stable while `out_valid && !out_ready`.
- Timeout: stub encryptor that never raises done. Required: `err_timeout` pulses exactly `TIMEOUT_CYCLES` cycles after entering WAIT, then `in_ready` = 1 and no `out_valid`.
- Reset mid-operation: assert `rstn` low after 6 input words, and again during DRAIN after 2 output words. Required: all outputs 0 and the state is LOAD_KEY; a following full vector produces the correct ciphertext.
- Done-at-timeout collision: stub asserts done on exactly the last WAIT cycle. Required: ciphertext is drained and `err_timeout` stays 0.
- `AES_KEY_REUSE_EN`: second block sent with `in_keep_key` = 1 and plaintext 00000000 ×4 under the FIPS key. Required: only 4 words accepted, and `aes_cipher_key` unchanged. With the macro undefined, the same stimulus loads those words as a key.
